// File: rtl/bp_mem_simple_responder.sv
// bp_mem_simple_responder
//   Memory-side responder for the BlackParrot CCE-MEM interface. Accepts one
//   command at a time, services it from an internal block-organised storage
//   array and returns exactly one response latency_p cycles after acceptance.
//
// Handshake semantics (one place, applies to every port below):
//   - Command side is valid/ready: a command transfers on a rising clk_i edge
//     where mem_cmd_v_i and mem_cmd_ready_o are both high.
//   - Response side is valid/yumi: mem_resp_v_o stays high with all fields
//     stable until the consumer pulses mem_resp_yumi_i, which it may only do
//     while mem_resp_v_o is high. No new command is taken in that same cycle.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   mem_cmd_v_i/ready_o       command handshake
//   mem_cmd_type_i            0 blk rd, 1 blk wr, 2 uc rd, 3 uc wr
//   mem_cmd_addr_i            byte address
//   mem_cmd_size_i            log2 bytes for uncached commands
//   mem_cmd_payload_i         opaque requester payload, echoed
//   mem_cmd_data_i            write data (uncached data in bits [63:0])
//   mem_resp_v_o/yumi_i       response handshake
//   mem_resp_type/addr/size/payload_o  echoed command fields
//   mem_resp_data_o           read data, zero for writes
module bp_mem_simple_responder #(
    parameter int paddr_width_p   = 40,
    parameter int block_width_p   = 512,
    parameter int els_p           = 64,
    parameter int payload_width_p = 8,
    parameter int latency_p       = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       mem_cmd_v_i,
    output logic                       mem_cmd_ready_o,
    input  logic [1:0]                 mem_cmd_type_i,
    input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
    input  logic [1:0]                 mem_cmd_size_i,
    input  logic [payload_width_p-1:0] mem_cmd_payload_i,
    input  logic [block_width_p-1:0]   mem_cmd_data_i,
    output logic                       mem_resp_v_o,
    input  logic                       mem_resp_yumi_i,
    output logic [1:0]                 mem_resp_type_o,
    output logic [paddr_width_p-1:0]   mem_resp_addr_o,
    output logic [1:0]                 mem_resp_size_o,
    output logic [payload_width_p-1:0] mem_resp_payload_o,
    output logic [block_width_p-1:0]   mem_resp_data_o
);

    localparam int off_w = $clog2(block_width_p / 8);
    localparam int idx_w = $clog2(els_p);
    localparam int cnt_w = (latency_p > 1) ? $clog2(latency_p) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                      state_q;
    logic [cnt_w-1:0]            cnt_q;
    logic                        ready_q;
    logic                        resp_v_q;
    logic [1:0]                  resp_type_q;
    logic [paddr_width_p-1:0]    resp_addr_q;
    logic [1:0]                  resp_size_q;
    logic [payload_width_p-1:0]  resp_payload_q;
    logic [block_width_p-1:0]    resp_data_q;

    logic [block_width_p-1:0]    mem_r [els_p];

    // Access datapath, evaluated combinationally against the incoming command.
    logic                        accept;
    logic                        is_uc;
    logic                        is_wr;
    logic [idx_w-1:0]            idx;
    logic [off_w-1:0]            size_mask;
    logic [off_w-1:0]            byte_off;
    logic [off_w+2:0]            bit_sh;
    logic [63:0]                 lane_mask;
    logic [block_width_p-1:0]    rd_block;
    logic [block_width_p-1:0]    uc_mask;
    logic [block_width_p-1:0]    uc_wdata;
    logic [block_width_p-1:0]    wr_block;
    logic [block_width_p-1:0]    rd_data;

    always_comb begin
        accept = mem_cmd_v_i & (state_q == IDLE);
        is_uc  = mem_cmd_type_i[1];
        is_wr  = mem_cmd_type_i[0];
        idx    = mem_cmd_addr_i[off_w +: idx_w];

        size_mask = '0;
        lane_mask = '0;
        case (mem_cmd_size_i)
            2'd0: begin size_mask = off_w'(0); lane_mask = 64'h0000_0000_0000_00ff; end
            2'd1: begin size_mask = off_w'(1); lane_mask = 64'h0000_0000_0000_ffff; end
            2'd2: begin size_mask = off_w'(3); lane_mask = 64'h0000_0000_ffff_ffff; end
            default: begin size_mask = off_w'(7); lane_mask = 64'hffff_ffff_ffff_ffff; end
        endcase

        // Uncached offsets are naturally aligned down to the access size.
        byte_off = mem_cmd_addr_i[off_w-1:0] & ~size_mask;
        bit_sh   = {byte_off, 3'b000};

        rd_block = mem_r[idx];
        uc_mask  = block_width_p'(lane_mask) << bit_sh;
        uc_wdata = block_width_p'(mem_cmd_data_i[63:0]) << bit_sh;

        // Uncached write is a read-modify-write of the addressed block.
        wr_block = is_uc ? ((rd_block & ~uc_mask) | (uc_wdata & uc_mask)) : mem_cmd_data_i;
        rd_data  = is_uc ? ((rd_block >> bit_sh) & block_width_p'(lane_mask)) : rd_block;
    end

    // Storage is deliberately not reset; a committed write survives a reset.
    always_ff @(posedge clk_i) begin
        if (accept && is_wr) begin
            mem_r[idx] <= wr_block;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            ready_q        <= 1'b1;
            resp_v_q       <= 1'b0;
            resp_type_q    <= '0;
            resp_addr_q    <= '0;
            resp_size_q    <= '0;
            resp_payload_q <= '0;
            resp_data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        resp_type_q    <= mem_cmd_type_i;
                        resp_addr_q    <= mem_cmd_addr_i;
                        resp_size_q    <= mem_cmd_size_i;
                        resp_payload_q <= mem_cmd_payload_i;
                        resp_data_q    <= is_wr ? '0 : rd_data;
                        cnt_q          <= cnt_w'(latency_p - 1);
                        ready_q        <= 1'b0;
                        if (latency_p == 1) begin
                            state_q  <= RESP;
                            resp_v_q <= 1'b1;
                        end else begin
                            state_q  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    // Counter is about to reach zero: response goes valid now.
                    if (cnt_q == cnt_w'(1)) begin
                        state_q  <= RESP;
                        resp_v_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (mem_resp_yumi_i) begin
                        state_q  <= IDLE;
                        resp_v_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    resp_v_q <= 1'b0;
                    ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign mem_cmd_ready_o    = ready_q;
    assign mem_resp_v_o       = resp_v_q;
    assign mem_resp_type_o    = resp_type_q;
    assign mem_resp_addr_o    = resp_addr_q;
    assign mem_resp_size_o    = resp_size_q;
    assign mem_resp_payload_o = resp_payload_q;
    assign mem_resp_data_o    = resp_data_q;

    // Yumi outside RESP is a protocol error by the consumer.
    yumi_only_in_resp: assert property (
        @(posedge clk_i) disable iff (reset_i) mem_resp_yumi_i |-> (state_q == RESP)
    );

endmodule
